rx_module: RTL
==============

# rx_module

UART receiver for the serial-port design: the receive-side counterpart to the existing transmit path. Recovers 8N1 frames (LSB first) from the asynchronous `rx_pin_in` line. Presents each good byte on `rx_data` with a one-cycle `rx_done_sig` strobe, and flags bad stop bits with `rx_frame_err`. Sits beside `tx_module` in a top-level loopback or echo design, driven by the same system clock.

## Interface

Parameters:

- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.

Ports:

- `clk`, input, 1: system clock, rising-edge.
- `rst`, input, 1: one clock; reset is synchronous and active-high.
- `rx_en_sig`, input, 1: receive enable; low forces IDLE.
- `rx_pin_in`, input, 1: asynchronous serial line, idle high.
- `rx_data`, output, 8: last good byte; held until the next good frame.
- `rx_done_sig`, output, 1: one-cycle strobe, `rx_data` is valid that cycle.
- `rx_frame_err`, output, 1: one-cycle strobe, stop bit sampled low.
- `rx_busy`, output, 1: high in START/DATA/STOP.

## Operation

- Derived constants:
  - BPS = CLK_FREQ/BAUD, integer division.
  - HALF = BPS/2.
  - BPS ≥ 4 is required; an elaboration-time assertion enforces it.
  - Counter width is clog2(BPS).
- Input synchroniser: `rx_pin_in` passes through s1 then s2, and s3 holds the previous value of s2.
  - s1/s2/s3 reset to 1.
  - Falling edge = s3 & ~s2.
- IDLE:
  - On falling edge with `rx_en_sig`=1, go to START, clear the baud counter and clear the bit index.
- START:
  - Count 0..HALF-1.
  - At HALF-1, sample s2. If 0, go to DATA and clear the counter. If 1 (glitch), go to IDLE with no strobe.
- DATA:
  - Count 0..BPS-1.
  - At BPS-1, shift s2 into the shift register MSB (shift right, so LSB-first order is preserved) and increment the bit index.
  - After bit index 7, go to STOP.
- STOP:
  - Count 0..BPS-1. At BPS-1, sample s2.
  - If 1: `rx_data` ← shift register and pulse `rx_done_sig`.
  - If 0: pulse `rx_frame_err` and leave `rx_data` unchanged.
  - Return to IDLE in the same cycle, i.e. at mid-stop-bit, so a start bit that immediately follows is caught.
- `rx_en_sig`=0 in any state: next state is IDLE, no strobe, `rx_data` is untouched.
- `rst`=1 at any time, including mid-frame:
  - State goes to IDLE; counter, bit index and shift register clear.
  - `rx_data`=8'h00, `rx_done_sig`=0, `rx_frame_err`=0, `rx_busy`=0.
  - s1/s2/s3 go to 1.
- `rx_done_sig` and `rx_frame_err` are never both high in the same cycle.

## Timing

- Let edge 0 be the first rising edge at which `rx_pin_in` is sampled low.
  - State = START after edge 3.
  - Start-bit sample at edge 3+HALF.
  - Data bit k (k=0..7) sampled at edge 3+HALF+(k+1)·BPS.
  - Stop bit sampled at edge 3+HALF+9·BPS.
  - `rx_done_sig`/`rx_frame_err` is high for exactly the cycle following that edge.
- All outputs are registered; there are no combinational paths from input to output.
- `rx_busy` rises after edge 3 and falls in the same cycle as the strobe.
- Maximum tolerated clock/baud mismatch: ±HALF/(9.5·BPS), about 5%.

## Structure

- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t`.
  - Default `CLK_FREQ`/`BAUD` localparams.
  - Function computing BPS; shared with `tx_module`'s baud logic.
- One sub-module, `rx_bps_module`: baud counter.
  - Inputs: `clk`, `rst`, clear, mode (half/full).
  - Output: one-cycle `bps_tick` at HALF-1 or BPS-1.
- `rx_module` holds the synchroniser, FSM, shift register and output registers.

## Test plan

All scenarios use CLK_FREQ=16, BAUD=1, giving BPS=16 and HALF=8.

- **Single byte:** 8N1 frame 0x55, edge 0 at cycle 10.
  - `rx_done_sig` high exactly at cycle 10+3+8+144+1 = 166.
  - `rx_data`=8'h55, `rx_frame_err` never high.
- **Back-to-back:** frames 0xA5 then 0x3C with zero idle gap (second start bit directly after stop).
  - Two `rx_done_sig` pulses exactly 160 cycles apart.
  - `rx_data` = 0xA5, then 0x3C.
- **Glitch:** line low for 3 cycles, then high.
  - `rx_busy` pulses for 8 cycles; no `rx_done_sig` or `rx_frame_err`.
  - `rx_data` keeps its prior value.
- **Framing error:** 0xF0 with stop bit driven 0.
  - `rx_frame_err` one-cycle pulse; `rx_data` keeps its previous value (8'h00 after reset).
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4 of 0x81.
  - All outputs at reset values next cycle; no strobe for that frame.
  - A following clean 0x81 frame is received correctly.
- **Enable low:** `rx_en_sig`=0 during data bits.
  - Frame aborted, `rx_busy`=0 next cycle.
  - With `rx_en_sig` held low, a full frame produces no strobe.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART types, default line parameters and baud arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 9600;

  // Clocks per bit; the transmit side uses the same rounding so both agree.
  function automatic int unsigned calc_bps(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_module_if.sv
`default_nettype none
// ============================================================================
//  Module   : rx_module_if
//  Purpose  : Serial line, enable and received-byte signals of the UART receiver.
//  Revision : 1.0 - initial release
// ============================================================================
interface rx_module_if;
  logic       rx_en_sig;
  logic       rx_pin_in;
  logic [7:0] rx_data;
  logic       rx_done_sig;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (
    output rx_en_sig, rx_pin_in,
    input  rx_data, rx_done_sig, rx_frame_err, rx_busy
  );

  modport slave (
    input  rx_en_sig, rx_pin_in,
    output rx_data, rx_done_sig, rx_frame_err, rx_busy
  );
endinterface
`default_nettype wire

// File: rtl/rx_bps_module.sv
`default_nettype none
// ============================================================================
//  Module   : rx_bps_module
//  Purpose  : Baud counter; one-cycle tick at HALF-1 (half mode) or BPS-1.
//  Revision : 1.0 - initial release
// ============================================================================
module rx_bps_module #(
  parameter int unsigned BPS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic half_mode,
  output logic bps_tick
);

  localparam int unsigned   CW        = $clog2(BPS);
  localparam logic [CW-1:0] FULL_LAST = CW'(BPS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BPS / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter wraps on its own tick so consecutive bit periods need no clear.
  always_comb begin
    bps_tick = (cnt_q == (half_mode ? HALF_LAST : FULL_LAST));
    cnt_d    = cnt_q + CW'(1);
    if (clr || bps_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_module.sv
`default_nettype none
// ============================================================================
//  Module   : rx_module
//  Purpose  : 8N1 UART receiver: synchroniser, frame FSM, shift and output regs.
//  Revision : 1.0 - initial release
// ============================================================================
module rx_module
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic        clk,
  input  logic        rst,
  rx_module_if.slave  rx_if
);

  localparam int unsigned BPS = calc_bps(CLK_FREQ, BAUD);

  generate
    if (BPS < 4) begin : g_bps_chk
      $error("rx_module: CLK_FREQ/BAUD must be at least 4");
    end
  endgenerate

  rx_state_t  state_q, state_d;
  logic       s1_q, s2_q, s3_q, fall_q;
  logic       s1_d, s2_d, s3_d, fall_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       cnt_clr, half_mode, bps_tick;

  rx_bps_module #(.BPS(BPS)) u_bps (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .half_mode (half_mode),
    .bps_tick  (bps_tick)
  );

  // The edge detect is registered, so START is entered three edges after
  // the line is first sampled low.
  always_comb begin
    s1_d   = rx_if.rx_pin_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    fall_d = s3_q & ~s2_q;
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cnt_clr   = (state_q == IDLE);
    half_mode = (state_q == START);

    case (state_q)
      IDLE: begin
        if (fall_q) begin
          state_d   = START;
          bit_idx_d = '0;
        end
      end
      START: begin
        if (bps_tick) begin
          state_d = s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bps_tick) begin
          shift_d   = {s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit leaves half a bit to catch the next start.
        if (bps_tick) begin
          if (s2_q) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rx_if.rx_en_sig) begin
      state_d = IDLE;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
      fall_q    <= 1'b0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      fall_q    <= fall_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_if.rx_data      = data_q;
  assign rx_if.rx_done_sig  = done_q;
  assign rx_if.rx_frame_err = err_q;
  assign rx_if.rx_busy      = busy_q;

endmodule
`default_nettype wire
